// File: rtl/text_console_writer.sv
// text_console_writer
//   Turns a byte stream into writes to a COLUMNS x ROWS character buffer,
//   with a cursor, CR/LF/BS handling and hardware scrolling. The buffer is
//   treated as a ring of rows; scroll_row names the physical row the display
//   shows on top, so scrolling costs only one row clear instead of a copy.
//
// Ports
//   CLOCK_50    system clock, rising edge
//   reset       synchronous, active-high
//   char_valid  producer offers char_data
//   char_data   ASCII byte offered
//   char_ready  registered; byte is taken on an edge with valid & ready
//   tb_we       text buffer write strobe
//   tb_addr     physical cell address, phys_row*COLUMNS + col
//   tb_wdata    character written
//   scroll_row  physical row shown as the top display line
//   cursor_col  logical cursor column
//   cursor_row  logical cursor row
module text_console_writer #(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 24
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        tb_we,
  output logic [10:0] tb_addr,
  output logic [7:0]  tb_wdata,
  output logic [4:0]  scroll_row,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam logic [10:0] LAST_CELL = 11'(COLUMNS * ROWS - 1);
  localparam logic [10:0] COLS11    = 11'(COLUMNS);
  localparam logic [6:0]  LAST_COL  = 7'(COLUMNS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [5:0]  ROWS6     = 6'(ROWS);
  localparam logic [7:0]  SPACE     = 8'h20;

  typedef enum logic [1:0] {INIT_CLEAR, IDLE, ROW_CLEAR} state_t;

  state_t      state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [4:0]  scroll_row_q, scroll_row_d;
  logic [6:0]  cursor_col_q, cursor_col_d;
  logic [4:0]  cursor_row_q, cursor_row_d;
  logic        tb_we_q, tb_we_d;
  logic [10:0] tb_addr_q, tb_addr_d;
  logic [7:0]  tb_wdata_q, tb_wdata_d;
  logic        char_ready_q, char_ready_d;

  logic [5:0]  phys_sum;
  logic [4:0]  phys_row;
  logic [10:0] cell_addr;
  logic [10:0] clr_addr;
  logic        accept;
  logic        printable;
  logic        is_lf;
  logic        newline;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_row_d    = clr_row_q;
    scroll_row_d = scroll_row_q;
    cursor_col_d = cursor_col_q;
    cursor_row_d = cursor_row_q;
    tb_we_d      = 1'b0;
    tb_addr_d    = tb_addr_q;
    tb_wdata_d   = tb_wdata_q;
    newline      = 1'b0;

    // Logical row -> physical row through the ring offset.
    phys_sum  = {1'b0, scroll_row_q} + {1'b0, cursor_row_q};
    phys_row  = (phys_sum >= ROWS6) ? 5'(phys_sum - ROWS6) : phys_sum[4:0];
    cell_addr = 11'(phys_row) * COLS11 + 11'(cursor_col_q);
    clr_addr  = 11'(clr_row_q) * COLS11 + clr_cnt_q;

    accept    = char_valid && char_ready_q && (state_q == IDLE);
    printable = (char_data >= 8'h20) && (char_data <= 8'h7E);
    is_lf     = (char_data == 8'h0A);

    case (state_q)
      INIT_CLEAR: begin
        tb_we_d    = 1'b1;
        tb_addr_d  = clr_cnt_q;
        tb_wdata_d = SPACE;
        if (clr_cnt_q == LAST_CELL) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
        end
      end

      IDLE: begin
        if (accept) begin
          if (printable) begin
            tb_we_d    = 1'b1;
            tb_addr_d  = cell_addr;
            tb_wdata_d = char_data;
            if (cursor_col_q == LAST_COL) begin
              cursor_col_d = '0;
              newline      = 1'b1;
            end else begin
              cursor_col_d = cursor_col_q + 7'd1;
            end
          end else if (is_lf) begin
            cursor_col_d = '0;
            newline      = 1'b1;
          end else if (char_data == 8'h0D) begin
            cursor_col_d = '0;
          end else if (char_data == 8'h08) begin
            if (cursor_col_q != '0) cursor_col_d = cursor_col_q - 7'd1;
          end

          if (newline) begin
            if (cursor_row_q != LAST_ROW) begin
              cursor_row_d = cursor_row_q + 5'd1;
            end else begin
              scroll_row_d = (scroll_row_q == LAST_ROW) ? 5'd0 : scroll_row_q + 5'd1;
              clr_row_d    = scroll_row_q;
              state_d      = ROW_CLEAR;
              // An LF leaves the write port free, so the row clear starts on
              // this same edge; a wrapping printable uses it for the character.
              if (is_lf) begin
                tb_we_d    = 1'b1;
                tb_addr_d  = 11'(scroll_row_q) * COLS11;
                tb_wdata_d = SPACE;
                clr_cnt_d  = 11'd1;
              end else begin
                clr_cnt_d  = '0;
              end
            end
          end
        end
      end

      ROW_CLEAR: begin
        tb_we_d    = 1'b1;
        tb_addr_d  = clr_addr;
        tb_wdata_d = SPACE;
        if (clr_cnt_q == 11'(LAST_COL)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 11'd1;
        end
      end

      default: state_d = INIT_CLEAR;
    endcase

    // Ready only once the machine has been sitting in IDLE, so it drops the
    // cycle after a scroll handshake and rises one cycle after a clear ends.
    char_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // Reset parks the machine at the start of INIT_CLEAR with all outputs low;
  // the first write appears on the first edge after release.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= INIT_CLEAR;
      clr_cnt_q    <= '0;
      clr_row_q    <= '0;
      scroll_row_q <= '0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
      tb_we_q      <= 1'b0;
      tb_addr_q    <= '0;
      tb_wdata_q   <= '0;
      char_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_row_q    <= clr_row_d;
      scroll_row_q <= scroll_row_d;
      cursor_col_q <= cursor_col_d;
      cursor_row_q <= cursor_row_d;
      tb_we_q      <= tb_we_d;
      tb_addr_q    <= tb_addr_d;
      tb_wdata_q   <= tb_wdata_d;
      char_ready_q <= char_ready_d;
    end
  end

  assign char_ready = char_ready_q;
  assign tb_we      = tb_we_q;
  assign tb_addr    = tb_addr_q;
  assign tb_wdata   = tb_wdata_q;
  assign scroll_row = scroll_row_q;
  assign cursor_col = cursor_col_q;
  assign cursor_row = cursor_row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: every expected buffer write is queued
// ahead of time and a negedge monitor pops and compares each tb_we strobe.
module tb_text_console_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        tb_we;
  logic [10:0] tb_addr;
  logic [7:0]  tb_wdata;
  logic [4:0]  scroll_row;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int passes = 0;
  logic [18:0] expq[$];

  text_console_writer #(.COLUMNS(80), .ROWS(24)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .tb_we      (tb_we),
    .tb_addr    (tb_addr),
    .tb_wdata   (tb_wdata),
    .scroll_row (scroll_row),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushWrite(input int addr, input int data);
    expq.push_back({11'(addr), 8'(data)});
  endtask

  task automatic pushClears(input int base, input int n);
    for (int i = 0; i < n; i++) pushWrite(base + i, 8'h20);
  endtask

  // Monitor: each strobe must match the oldest queued write.
  always @(negedge CLOCK_50) begin
    if (tb_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected write: got addr %0d data 0x%02h, expected no write",
                 tb_addr, tb_wdata);
      end else begin
        logic [18:0] e;
        e = expq.pop_front();
        checkOutput("write addr", int'(tb_addr), int'(e[18:8]));
        checkOutput("write data", int'(tb_wdata), int'(e[7:0]));
      end
    end
  end

  // Offers a byte and holds it until the DUT takes it; returns 1ns after the
  // accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!char_ready) begin
      checkOutput("handshake timeout", 0, 1);
      char_valid = 1'b0;
      return;
    end
    @(posedge CLOCK_50);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tb_we"}, int'(tb_we), 0);
    checkOutput({tag, " tb_addr"}, int'(tb_addr), 0);
    checkOutput({tag, " tb_wdata"}, int'(tb_wdata), 0);
    checkOutput({tag, " char_ready"}, int'(char_ready), 0);
    checkOutput({tag, " scroll_row"}, int'(scroll_row), 0);
    checkOutput({tag, " cursor_col"}, int'(cursor_col), 0);
    checkOutput({tag, " cursor_row"}, int'(cursor_row), 0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int row_moved;

    // Reset, then the full-screen clear and the ready handover.
    repeat (3) @(negedge CLOCK_50);
    checkAllZero("reset");
    pushClears(0, 1920);
    reset = 1'b0;
    n = 0;
    while (!char_ready && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput("init ready delay", n, 1921);
    checkOutput("init writes drained", expq.size(), 0);

    // 'A','B' at row 0: addresses 0 and 1, one cycle after each handshake.
    pushWrite(0, 8'h41);
    applyStimulus(8'h41);
    @(negedge CLOCK_50);
    checkOutput("A write latency", int'(tb_we), 1);
    pushWrite(1, 8'h42);
    applyStimulus(8'h42);
    @(negedge CLOCK_50);
    checkOutput("B write latency", int'(tb_we), 1);
    checkOutput("col after AB", int'(cursor_col), 2);

    // Backspace saturates at column 0.
    applyStimulus(8'h08);
    applyStimulus(8'h08);
    applyStimulus(8'h08);
    checkOutput("col after 3 BS", int'(cursor_col), 0);

    // Five characters to column 5, then CR.
    for (int i = 0; i < 5; i++) begin
      pushWrite(i, 8'h61 + i);
      applyStimulus(8'(8'h61 + i));
    end
    checkOutput("col after 5 chars", int'(cursor_col), 5);
    applyStimulus(8'h0D);
    checkOutput("col after CR", int'(cursor_col), 0);

    // BEL is swallowed: no write, cursor stays put.
    applyStimulus(8'h07);
    repeat (2) @(negedge CLOCK_50);
    checkOutput("col after BEL", int'(cursor_col), 0);
    checkOutput("row after BEL", int'(cursor_row), 0);
    checkOutput("no pending writes", expq.size(), 0);

    // A full row of 80 characters wraps to row 1.
    for (int i = 0; i < 80; i++) begin
      pushWrite(i, 8'h30 + (i % 64));
      applyStimulus(8'(8'h30 + (i % 64)));
    end
    checkOutput("col after 80 chars", int'(cursor_col), 0);
    checkOutput("row after 80 chars", int'(cursor_row), 1);

    // LFs down to the bottom row, no writes.
    for (int i = 0; i < 22; i++) applyStimulus(8'h0A);
    checkOutput("row after 22 LF", int'(cursor_row), 23);
    checkOutput("scroll before LF at bottom", int'(scroll_row), 0);

    // LF on the bottom row scrolls and clears physical row 0.
    pushClears(0, 80);
    applyStimulus(8'h0A);
    n = 0;
    row_moved = 0;
    do begin
      @(negedge CLOCK_50);
      if (!char_ready) n++;
      if (cursor_row != 5'd23 || scroll_row != 5'd1) row_moved = 1;
    end while (!char_ready && n < 500);
    checkOutput("ready low cycles on scroll", n, 80);
    checkOutput("cursor/scroll stable in clear", row_moved, 0);
    checkOutput("scroll after LF", int'(scroll_row), 1);
    checkOutput("row after scroll", int'(cursor_row), 23);

    // Logical row 23 now lives in physical row 0.
    pushWrite(0, 8'h58);
    applyStimulus(8'h58);
    @(negedge CLOCK_50);
    checkOutput("X write latency", int'(tb_we), 1);
    checkOutput("col after X", int'(cursor_col), 1);

    // Second scroll clears physical row 1; reset lands on its 40th write.
    pushClears(80, 40);
    applyStimulus(8'h0A);
    repeat (40) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkAllZero("mid-clear reset");
    checkOutput("clear aborted cleanly", expq.size(), 0);
    @(negedge CLOCK_50);

    // Release with a byte already offered: it waits out the full clear.
    pushClears(0, 1920);
    pushWrite(0, 8'h51);
    reset = 1'b0;
    applyStimulus(8'h51);
    repeat (2) @(negedge CLOCK_50);
    checkOutput("col after Q", int'(cursor_col), 1);
    checkOutput("final queue empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLUMNS, default 80, the text columns per row.
REQ-002 SHALL have parameter ROWS, default 24, the text rows in the buffer.
REQ-003 SHALL have port CLOCK_50, input, 1, the system clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port char_valid, input, 1, meaning the producer offers a byte.
REQ-006 SHALL have port char_data, input, 8, the offered ASCII byte.
REQ-007 SHALL have port char_ready, output, 1, a registered output meaning the block accepts a byte this cycle.
REQ-008 SHALL have port tb_we, output, 1, the text buffer write strobe.
REQ-009 SHALL have port tb_addr, output, 11, the physical cell address (phys_row*COLUMNS + col), range 0..1919.
REQ-010 SHALL have port tb_wdata, output, 8, the character written to the text buffer.
REQ-011 SHALL have port scroll_row, output, 5, the physical row the display shows as its top line (0..ROWS-1).
REQ-012 SHALL have port cursor_col, output, 7, the logical cursor column (0..COLUMNS-1).
REQ-013 SHALL have port cursor_row, output, 5, the logical cursor row (0..ROWS-1).

Function
REQ-014 SHALL implement three states: INIT_CLEAR, IDLE and ROW_CLEAR.
REQ-015 SHALL accept a byte only on a rising edge where char_valid=1 and char_ready=1.
REQ-016 SHALL keep a byte offered while char_ready=0 unconsumed; the producer holds it.
REQ-017 SHALL drive char_ready=1 only in IDLE.
REQ-018 SHALL deassert char_ready in the cycle immediately after a handshake that causes entry to ROW_CLEAR.
REQ-019 SHALL, in INIT_CLEAR, assert tb_we every cycle with tb_wdata=0x20 and tb_addr stepping 0,1,...,1919.
REQ-020 SHALL enter IDLE in the cycle after the write to address 1919.
REQ-021 SHALL compute the physical row as phys_row = scroll_row + cursor_row, minus ROWS if the sum is >= ROWS, using a 6-bit intermediate.
REQ-022 SHALL, for an accepted printable byte (0x20..0x7E), assert tb_we=1 in the next cycle with tb_wdata equal to the byte and tb_addr equal to phys_row*80 + cursor_col, using pre-update cursor values.
REQ-023 SHALL keep write latency at exactly 1 cycle and hold tb_we=0 in every other IDLE cycle.
REQ-024 SHALL, after a printable byte, increment cursor_col; at cursor_col=79 it sets cursor_col=0 and performs a newline.
REQ-025 SHALL, on 0x0A (LF), set cursor_col=0 and perform a newline; no write occurs.
REQ-026 SHALL, on 0x0D (CR), set cursor_col=0; no write occurs.
REQ-027 SHALL, on 0x08 (BS), decrement cursor_col, saturating at 0; no write occurs.
REQ-028 SHALL consume all other bytes with no write and no cursor change.
REQ-029 SHALL, on a newline with cursor_row<23, increment cursor_row and stay in IDLE.
REQ-030 SHALL, on a newline with cursor_row=23, keep cursor_row=23, set scroll_row=(scroll_row+1) mod 24, and enter ROW_CLEAR.
REQ-031 SHALL, in ROW_CLEAR, write 0x20 to the 80 cells of the new bottom physical row (the old scroll_row), columns 0..79, one per cycle, then return to IDLE.
REQ-032 SHALL hold cursor and scroll outputs stable during INIT_CLEAR and ROW_CLEAR.

Reset
REQ-033 SHALL, while reset=1, hold tb_we=0, tb_addr=0, tb_wdata=0, char_ready=0, scroll_row=0, cursor_col=0 and cursor_row=0.
REQ-034 SHALL enter INIT_CLEAR on the first edge after reset deasserts and issue the first write (address 0) in that cycle.
REQ-035 SHALL abort INIT_CLEAR, ROW_CLEAR or a pending write when reset asserts mid-operation, with no further writes until INIT_CLEAR restarts.

Verification
REQ-036 SHALL cover: reset then release -> 1920 consecutive writes of 0x20 to addresses 0..1919, then char_ready=1 on the next cycle.
REQ-037 SHALL cover: 'A'(0x41) then 'B' -> writes (0,0x41) and (1,0x42) each 1 cycle after handshake; cursor_col=2.
REQ-038 SHALL cover: 80 printable bytes from col 0, row 0 -> last write at address 79; cursor_col=0, cursor_row=1.
REQ-039 SHALL cover: cursor_row=23 then LF -> scroll_row=1, char_ready=0 for 80 cycles, writes 0x20 at addresses 0..79; next 'X' writes address 0 (phys row 0 = logical row 23).
REQ-040 SHALL cover: BS at col 0 -> col stays 0; CR at col 5 -> col 0; byte 0x07 -> no write, cursor unchanged.
REQ-041 SHALL cover: reset asserted at ROW_CLEAR cycle 40 -> tb_we=0 next cycle, all outputs 0; full INIT_CLEAR follows release.
